// File: rtl/dmem_port_arbiter.sv
// Arbitrates BRAM port 2 between the core LSU (r0) and the loader (r1): round-robin,
// r1 burst lock with an r0 starvation guard, registered-read response routing.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_lock,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  typedef enum logic {ARB, LOCK1} state_t;

  state_t        state, state_nxt;
  logic          last_r1;          // 1: r1 won most recently, so r0 is favoured next
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          gnt0, gnt1;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ARB: begin
        starve_nxt = '0;
        if (r0_req && r1_req) begin
          gnt0 = last_r1;
          gnt1 = ~last_r1;
        end else begin
          gnt0 = r0_req;
          gnt1 = r1_req;
        end
        if (gnt1 && r1_lock) state_nxt = LOCK1;
      end
      LOCK1: begin
        // Starvation guard overrides the lock for exactly one cycle.
        if (r0_req && starve_cnt == CNT_MAX) gnt0 = 1'b1;
        else if (r1_req)                     gnt1 = 1'b1;
        if (!r0_req || gnt0)          starve_nxt = '0;
        else if (starve_cnt != CNT_MAX) starve_nxt = starve_cnt + 1'b1;
        if (!r1_lock) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign mem_we    = (gnt0 & r0_we) | (gnt1 & r1_we);
  assign mem_addr  = gnt0 ? r0_addr  : (gnt1 ? r1_addr  : '0);
  assign mem_wdata = gnt0 ? r0_wdata : (gnt1 ? r1_wdata : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      last_r1    <= 1'b1;
      starve_cnt <= '0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (gnt0)      last_r1 <= 1'b0;
      else if (gnt1) last_r1 <= 1'b1;
      // BRAM read data arrives one cycle after the address; tag it with its owner.
      r0_rvalid  <= gnt0 & ~r0_we;
      r1_rvalid  <= gnt1 & ~r1_we;
    end
  end

  assign r0_rdata = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: BRAM emulation, arbitration reference model, response scoreboard.
module tb_dmem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SM = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic          r0_req, r0_we, r0_gnt, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // BRAM port 2 emulation: registered read, read-before-write.
  bit [DW-1:0] bram [256];
  initial mem_rdata = '0;
  always @(posedge clock) begin
    if (mem_we) bram[mem_addr] <= mem_wdata;
    mem_rdata <= bram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  rsp_t q0[$];
  rsp_t q1[$];

  // Reference model: who owns the port this cycle, and what each read must return.
  bit [DW-1:0] ref_mem [256];
  bit  m_locked = 1'b0;
  int  m_wait   = 0;
  int  m_last   = 1;
  int  m_win_d  = -1;

  always @(negedge clock) begin
    int win;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    if (!reset) begin
      chk("rst_r0_gnt", r0_gnt, 0);
      chk("rst_r1_gnt", r1_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_locked = 1'b0; m_wait = 0; m_last = 1; m_win_d = -1;
      q0.delete(); q1.delete();
    end else begin
      if (!m_locked) begin
        if (r0_req && r1_req) win = (m_last == 1) ? 0 : 1;
        else if (r0_req)      win = 0;
        else if (r1_req)      win = 1;
        else                  win = -1;
      end else begin
        if (r0_req && m_wait >= SM) win = 0;
        else if (r1_req)            win = 1;
        else                        win = -1;
      end
      chk("r0_gnt", r0_gnt, win == 0);
      chk("r1_gnt", r1_gnt, win == 1);
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      if (win == 0) begin e_we = r0_we; e_addr = r0_addr; e_wdata = r0_wdata; end
      if (win == 1) begin e_we = r1_we; e_addr = r1_addr; e_wdata = r1_wdata; end
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      if (win == 0 && !r0_we) q0.push_back('{cyc + 1, ref_mem[e_addr]});
      if (win == 1 && !r1_we) q1.push_back('{cyc + 1, ref_mem[e_addr]});
      if (win >= 0 && e_we) ref_mem[e_addr] = e_wdata;
      // Consecutive denied cycles of r0 while the port is locked.
      if (!m_locked || !r0_req || win == 0) m_wait = 0;
      else if (m_wait < SM)                 m_wait = m_wait + 1;
      if (!m_locked) m_locked = (win == 1) && r1_lock;
      else           m_locked = r1_lock;
      if (win >= 0) m_last = win;
      m_win_d = win;
    end
  end

  // Monitor: each read response must appear exactly on its due cycle.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_r0_rvalid", r0_rvalid, 0);
      chk("rst_r1_rvalid", r1_rvalid, 0);
    end else begin
      if (q0.size() > 0 && q0[0].due == cyc) begin
        chk("r0_rvalid", r0_rvalid, 1);
        chk("r0_rdata", r0_rdata, q0[0].data);
        void'(q0.pop_front());
      end else begin
        chk("r0_rvalid_idle", r0_rvalid, 0);
        chk("r0_rdata_idle", r0_rdata, 0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        chk("r1_rvalid", r1_rvalid, 1);
        chk("r1_rdata", r1_rdata, q1[0].data);
        void'(q1.pop_front());
      end else begin
        chk("r1_rvalid_idle", r1_rvalid, 0);
        chk("r1_rdata_idle", r1_rdata, 0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set0(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d;
  endtask

  task automatic set1(input logic rq, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic lk);
    r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d; r1_lock = lk;
  endtask

  task automatic idle();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step(); step();
    reset = 1'b1;

    // Reset in the cycle a read response would appear; request held through reset.
    set0(1, 0, 8'h10, 0);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    idle();
    step();

    // Single requester write then read.
    set0(1, 1, 8'h10, 32'hDEADBEEF);
    step();
    set0(1, 0, 8'h10, 0);
    step();
    idle();
    step(); step();

    // Contention from reset: alternating grants.
    do_reset();
    set0(1, 0, 8'h10, 0);
    set1(1, 0, 8'h11, 0, 0);
    repeat (8) step();
    idle();
    step(); step();

    // Lock burst of six writes, then release.
    set0(1, 0, 8'h30, 0);
    for (int i = 0; i < 6; i++) begin
      set1(1, 1, AW'(i), 32'h100 + i, 1);
      step();
    end
    set1(1, 1, 8'h06, 32'h106, 0);
    step();
    set1(0, 0, 0, 0, 0);
    step();
    idle();
    step(); step();

    // Starvation guard under a continuous locked burst.
    set0(1, 0, 8'h02, 0);
    for (int i = 0; i < 30; i++) begin
      set1(1, (i % 2) == 0, AW'(8'h40 + i), $urandom, 1);
      step();
    end
    idle();
    step(); step(); step();

    // Write by r1 immediately followed by read of same address by r0.
    set1(1, 1, 8'h20, 32'h5A5A5A5A, 0);
    step();
    set1(0, 0, 0, 0, 0);
    set0(1, 0, 8'h20, 0);
    step();
    idle();
    step(); step();

    // Randomized traffic; requests held until granted.
    for (int i = 0; i < 3000; i++) begin
      if (!r0_req || m_win_d == 0)
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom);
      if (!r1_req || m_win_d == 1)
        set1($urandom_range(0, 2) != 0, $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom, r1_lock);
      if ($urandom_range(0, 11) == 0) r1_lock = ~r1_lock;
      if (i == 1500) begin
        idle();
        do_reset();
      end
      step();
    end
    idle();
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
